// File: rtl/periodic_framer_pkg.sv
// Shared types and defaults for the periodic symbol framer.
package periodic_framer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OFFSET = 2'd1,
        S_FRAME  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // Settings-bus addresses
    localparam int SR_FRAME_LEN_DEF  = 16;
    localparam int SR_GAP_LEN_DEF    = 17;
    localparam int SR_OFFSET_DEF     = 18;
    localparam int SR_MAX_FRAMES_DEF = 19;

    // Register values after reset
    localparam int FRAME_LEN_RST  = 64;
    localparam int GAP_LEN_RST    = 16;
    localparam int OFFSET_RST     = 0;
    localparam int MAX_FRAMES_RST = 1;

endpackage

// File: rtl/setting_reg.sv
// Single settings-bus register: captures data when the strobe hits its address.
module setting_reg #(
    parameter int ADDR      = 0,
    parameter int WIDTH     = 32,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] value
);

    // Capture on a matching write; value is visible the following cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= RESET_VAL[WIDTH-1:0];
        else if (strobe && (addr == ADDR[7:0]))
            value <= data;
    end

endmodule

// File: rtl/periodic_framer.sv
// Cuts a sample stream into fixed-length frames after a trigger, dropping the
// cyclic prefix between frames.
//
// state  | meaning
// IDLE   | discard samples, wait for a trigger
// OFFSET | discard samples between trigger and first frame
// FRAME  | pass samples through, tlast on the final one
// GAP    | discard cyclic prefix between frames
module periodic_framer
    import periodic_framer_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int LEN_W         = 16,
    parameter int SR_FRAME_LEN  = SR_FRAME_LEN_DEF,
    parameter int SR_GAP_LEN    = SR_GAP_LEN_DEF,
    parameter int SR_OFFSET     = SR_OFFSET_DEF,
    parameter int SR_MAX_FRAMES = SR_MAX_FRAMES_DEF
) (
    input  logic             ce_clk,
    input  logic             ce_rst,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_trig,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             busy,
    output logic [LEN_W-1:0] frame_cnt
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [LEN_W-1:0] flen_act, gap_act, off_act, max_act;
    logic [LEN_W-1:0] flen_sh, gap_sh, off_sh, max_sh;
    logic [LEN_W-1:0] cnt;
    state_t           state;

    logic             unused_set_data;
    assign unused_set_data = ^set_data[31:LEN_W];

    setting_reg #(.ADDR(SR_FRAME_LEN), .WIDTH(LEN_W), .RESET_VAL(FRAME_LEN_RST)) u_frame_len (
        .clk(ce_clk), .rst(ce_rst), .strobe(set_stb), .addr(set_addr),
        .data(set_data[LEN_W-1:0]), .value(flen_act));
    setting_reg #(.ADDR(SR_GAP_LEN), .WIDTH(LEN_W), .RESET_VAL(GAP_LEN_RST)) u_gap_len (
        .clk(ce_clk), .rst(ce_rst), .strobe(set_stb), .addr(set_addr),
        .data(set_data[LEN_W-1:0]), .value(gap_act));
    setting_reg #(.ADDR(SR_OFFSET), .WIDTH(LEN_W), .RESET_VAL(OFFSET_RST)) u_offset (
        .clk(ce_clk), .rst(ce_rst), .strobe(set_stb), .addr(set_addr),
        .data(set_data[LEN_W-1:0]), .value(off_act));
    setting_reg #(.ADDR(SR_MAX_FRAMES), .WIDTH(LEN_W), .RESET_VAL(MAX_FRAMES_RST)) u_max_frames (
        .clk(ce_clk), .rst(ce_rst), .strobe(set_stb), .addr(set_addr),
        .data(set_data[LEN_W-1:0]), .value(max_act));

    logic             bypass, frame_mode, last_beat, done, accept;
    logic [LEN_W-1:0] cur_flen, cur_gap, cur_max, flen_m1, frame_pos, fc_base, fc_next;

    // A zero-offset trigger is itself frame sample 0, so IDLE acts as FRAME
    // for that beat using the live register values (shadows not loaded yet).
    always_comb begin
        bypass     = (state == S_IDLE) && i_trig && (off_act == '0) && !ce_rst;
        frame_mode = (state == S_FRAME) || bypass;
        cur_flen   = (state == S_IDLE) ? flen_act : flen_sh;
        cur_gap    = (state == S_IDLE) ? gap_act  : gap_sh;
        cur_max    = (state == S_IDLE) ? max_act  : max_sh;
        frame_pos  = (state == S_IDLE) ? '0 : cnt;
        fc_base    = (state == S_IDLE) ? '0 : frame_cnt;
        flen_m1    = (cur_flen == '0) ? '0 : cur_flen - ONE;
        last_beat  = frame_mode && (frame_pos == flen_m1);
        fc_next    = (fc_base == '1) ? fc_base : fc_base + ONE;
        done       = (cur_max != '0) && (fc_next == cur_max);
        o_tdata    = i_tdata;
        o_tvalid   = frame_mode && i_tvalid;
        o_tlast    = last_beat;
        i_tready   = frame_mode ? o_tready : 1'b1;
        accept     = i_tvalid && i_tready;
        busy       = (state != S_IDLE);
    end

    // Sequencer: everything advances only on an accepted input sample
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            frame_cnt <= '0;
            flen_sh   <= LEN_W'(FRAME_LEN_RST);
            gap_sh    <= LEN_W'(GAP_LEN_RST);
            off_sh    <= LEN_W'(OFFSET_RST);
            max_sh    <= LEN_W'(MAX_FRAMES_RST);
        end else if (accept) begin
            if (state == S_IDLE && i_trig) begin
                flen_sh   <= flen_act;
                gap_sh    <= gap_act;
                off_sh    <= off_act;
                max_sh    <= max_act;
                frame_cnt <= '0;
            end
            if (frame_mode) begin
                if (last_beat) begin
                    frame_cnt <= fc_next;
                    cnt       <= '0;
                    if (done)
                        state <= S_IDLE;
                    else if (cur_gap == '0)
                        state <= S_FRAME;
                    else
                        state <= S_GAP;
                end else begin
                    state <= S_FRAME;
                    cnt   <= frame_pos + ONE;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_trig) begin
                            if (off_act == ONE) begin
                                state <= S_FRAME;
                                cnt   <= '0;
                            end else begin
                                state <= S_OFFSET;
                                cnt   <= ONE;
                            end
                        end
                    end
                    S_OFFSET: begin
                        if (cnt + ONE == off_sh) begin
                            state <= S_FRAME;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    S_GAP: begin
                        if (cnt == gap_sh - ONE) begin
                            state <= S_FRAME;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
